// File: rtl/xillybus_seekable_mem_pkg.sv
// Shared constants and elaboration helpers for the Xillybus seekable memory endpoint.
package xillybus_pkg;

  localparam int END_WRAP = 0;
  localparam int END_STOP = 1;

  function automatic bit data_w_legal(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/xillybus_seekable_mem_if.sv
// Host stream pair, seek port and app-side port of the seekable memory.
// Handshake: a strobe (user_r_rden/user_w_wren) is accepted on a rising bus_clk edge
// only while its empty/full flag is low; read data appears the cycle after acceptance.
interface xillybus_seekable_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) ();
  logic              user_r_rden;
  logic [DATA_W-1:0] user_r_data;
  logic              user_r_empty;
  logic              user_r_eof;
  logic              user_r_open;
  logic              user_w_wren;
  logic [DATA_W-1:0] user_w_data;
  logic              user_w_full;
  logic              user_w_open;
  logic [ADDR_W-1:0] user_addr;
  logic              user_addr_update;
  logic [ADDR_W-1:0] app_addr;
  logic              app_rden;
  logic [DATA_W-1:0] app_rdata;
  logic              app_wren;
  logic [DATA_W-1:0] app_wdata;
  logic              host_wr_evt;
  logic [ADDR_W-1:0] host_wr_addr;

  modport slave (
    input  user_r_rden, user_r_open, user_w_wren, user_w_data, user_w_open,
           user_addr, user_addr_update, app_addr, app_rden, app_wren, app_wdata,
    output user_r_data, user_r_empty, user_r_eof, user_w_full, app_rdata,
           host_wr_evt, host_wr_addr
  );

  modport master (
    output user_r_rden, user_r_open, user_w_wren, user_w_data, user_w_open,
           user_addr, user_addr_update, app_addr, app_rden, app_wren, app_wdata,
    input  user_r_data, user_r_empty, user_r_eof, user_w_full, app_rdata,
           host_wr_evt, host_wr_addr
  );
endinterface

// File: rtl/xillybus_seekable_mem_dpram.sv
// True dual-port read-first RAM; port A (host) wins a same-address write collision.
module xillybus_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_re,
  input  logic              a_we,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
  logic              b_we_eff;

  always_comb begin
    a_rdata_d = a_re ? mem[a_addr] : a_rdata_q;
    b_rdata_d = b_re ? mem[b_addr] : b_rdata_q;
    b_we_eff  = b_we && !(a_we && (a_addr == b_addr));
  end

  // Array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (a_we)     mem[a_addr] <= a_wdata;
    if (b_we_eff) mem[b_addr] <= b_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/xillybus_seekable_mem.sv
// Seekable memory endpoint: one auto-incrementing host pointer, wrap or stop-at-end, plus an app port.
module xillybus_seekable_mem
  import xillybus_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int END_MODE = END_WRAP
) (
  input  logic                      bus_clk,
  input  logic                      bus_rst,
  xillybus_seekable_mem_if.slave    bus
);
  generate
    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
      $error("xillybus_seekable_mem: DATA_W must be 8, 16 or 32");
    end
  endgenerate

  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              at_end_q, at_end_d;
  logic              evt_q, evt_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              rd_go, wr_go;
  logic [ADDR_W-1:0] ptr_addr;
  logic              unused_open;

  assign ptr_addr    = ptr_q[ADDR_W-1:0];
  assign unused_open = bus.user_r_open ^ bus.user_w_open;

  // Transfers always use the pre-seek pointer; a seek only decides where ptr goes next.
  always_comb begin
    rd_go = bus.user_r_rden && !at_end_q;
    wr_go = bus.user_w_wren && !at_end_q;
    ptr_d = ptr_q;
    if (bus.user_addr_update) begin
      ptr_d = {1'b0, bus.user_addr};
    end else if (rd_go || wr_go) begin
      if (END_MODE == END_STOP) ptr_d = ptr_q + (ADDR_W+1)'(1);
      else                      ptr_d = {1'b0, ptr_addr + ADDR_W'(1)};
    end
    at_end_d = (END_MODE == END_STOP) && ptr_d[ADDR_W];
    evt_d    = wr_go;
    waddr_d  = wr_go ? ptr_addr : waddr_q;
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      ptr_q    <= '0;
      at_end_q <= 1'b0;
      evt_q    <= 1'b0;
      waddr_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      at_end_q <= at_end_d;
      evt_q    <= evt_d;
      waddr_q  <= waddr_d;
    end
  end

  xillybus_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (bus_clk),
    .rst     (bus_rst),
    .a_addr  (ptr_addr),
    .a_re    (rd_go),
    .a_we    (wr_go),
    .a_wdata (bus.user_w_data),
    .a_rdata (bus.user_r_data),
    .b_addr  (bus.app_addr),
    .b_re    (bus.app_rden),
    .b_we    (bus.app_wren),
    .b_wdata (bus.app_wdata),
    .b_rdata (bus.app_rdata)
  );

  assign bus.user_r_empty = at_end_q;
  assign bus.user_r_eof   = at_end_q;
  assign bus.user_w_full  = at_end_q;
  assign bus.host_wr_evt  = evt_q;
  assign bus.host_wr_addr = waddr_q;
endmodule

// File: doc/xillybus_seekable_mem.md
# xillybus_seekable_mem

Parametrised seekable memory endpoint for a Xillybus addressed stream pair, generalised from the fixed 8-bit/32-entry memory stream to any data width and depth. Host reads and writes go through one auto-incrementing pointer that the host seeks with `user_addr`/`user_addr_update`. An end-of-memory mode selects wrap-around or stop-with-EOF. A second, independent port lets user logic read and write the same array concurrently. Sits between `xillybus_core` and application logic in the `bus_clk` domain.

## Interface
- `DATA_W`, 8, element width in bits; legal values 8, 16, 32.
- `ADDR_W`, 5, element address width; depth = 2**ADDR_W.
- `END_MODE`, 0, 0 = wrap at end; 1 = stop at end (full/empty/eof).

Ports:
- `bus_clk` in 1: sole clock.
- `bus_rst` in 1: asynchronous, active-high reset.
- `user_r_rden` in 1: host read strobe.
- `user_r_data` out DATA_W: read data, valid the cycle after `user_r_rden`.
- `user_r_empty` out 1: no data available.
- `user_r_eof` out 1: end of stream.
- `user_r_open` in 1: host read file open.
- `user_w_wren` in 1: host write strobe.
- `user_w_data` in DATA_W: host write data.
- `user_w_full` out 1: host write refused.
- `user_w_open` in 1: host write file open.
- `user_addr` in ADDR_W: seek address.
- `user_addr_update` in 1: load `user_addr` into the pointer.
- `app_addr` in ADDR_W: user-logic address.
- `app_rden` in 1: user-logic read enable.
- `app_rdata` out DATA_W: user-logic read data, one-cycle latency.
- `app_wren` in 1: user-logic write enable.
- `app_wdata` in DATA_W: user-logic write data.
- `host_wr_evt` out 1: one-cycle pulse for each accepted host write.
- `host_wr_addr` out ADDR_W: address of that host write, valid with `host_wr_evt`.

## Operation
- Pointer `ptr` is ADDR_W+1 bits wide. The MSB is used only when END_MODE=1.
- Host write, when `user_w_wren` is high and `user_w_full` is low:
  - mem[ptr] <= `user_w_data`.
  - ptr increments.
  - `host_wr_evt`/`host_wr_addr` register the write.
- Host read, when `user_r_rden` is high and `user_r_empty` is low:
  - `user_r_data` <= mem[ptr].
  - ptr increments.
- Simultaneous host read and write: both use the same old ptr. The read returns the old contents (read-first). ptr increments by exactly one.
- `user_addr_update`: ptr <= {0, `user_addr`}. This has priority over the increment. A transfer in the same cycle still uses the old ptr.
- END_MODE=0: ptr wraps modulo depth. `user_r_empty`, `user_r_eof` and `user_w_full` are constant 0.
- END_MODE=1: when ptr == depth, `user_r_empty`, `user_r_eof` and `user_w_full` are all 1, and strobes are ignored. A seek clears this condition.
- `user_r_open`/`user_w_open` do not affect ptr or the memory contents.
- App port:
  - `app_rdata` <= mem[`app_addr`] on `app_rden`; it holds its value otherwise.
  - `app_wren` writes `app_wdata`.
  - App read of an address being written in the same cycle returns the old data.
- Write collision (host and app writing the same address in the same cycle): the host wins. The app write is dropped, with no flag.
- Memory contents are not reset.

## Timing
- Reset values:
  - ptr = 0.
  - `user_r_data` = 0 and `app_rdata` = 0.
  - `host_wr_evt` = 0 and `host_wr_addr` = 0.
  - Flags take their END_MODE value for ptr = 0, i.e. all 0.
- Read latency is 1 cycle for both ports.
- Write-to-read visibility: a write in cycle N is readable by either port from cycle N+1.
- `host_wr_evt` rises in the cycle after the accepted write.
- Flags are registered and update in the cycle after the ptr change. A rden/wren arriving in the same cycle the flag rises is still honoured only if it is presented before that edge.
- Reset asserted mid-transfer: the in-flight data is discarded and outputs are forced to reset values immediately.

## Structure
- Shared package `xillybus_pkg`:
  - `END_WRAP`/`END_STOP` constants.
  - Legal-DATA_W check function.
- Sub-module `xillybus_dpram`: true dual-port, read-first, DATA_W x 2**ADDR_W RAM.
  - Port A carries the host side, port B the app side.
  - Same-address write priority goes to port A.
- Top level holds the pointer, flag and event logic.

## Test plan
- DATA_W=8, ADDR_W=5, wrap mode:
  - Stimulus: seek 30, write 0xA1, 0xA2, 0xA3.
  - Response: app reads of addresses 30, 31, 0 return 0xA1, 0xA2, 0xA3; `host_wr_addr` sequence is 30, 31, 0.
- END_MODE=1, ADDR_W=2:
  - Stimulus: seek 2, read 2 words.
  - Response: `user_r_empty` and `user_r_eof` go to 1 the cycle after the second rden, and `user_w_full` is 1.
  - Stimulus: seek 0.
  - Response: all three flags clear.
- DATA_W=32, ptr=4 holding 0x11223344:
  - Stimulus: simultaneous rden and wren of 0xDEADBEEF.
  - Response: `user_r_data` = 0x11223344, mem[4] = 0xDEADBEEF, ptr = 5.
- Write collision:
  - Stimulus: host writes 0x55 and app writes 0x66 to address 7 in the same cycle.
  - Response: an app read of address 7 returns 0x55.
- Seek with transfer:
  - Stimulus: `user_addr_update` (addr 9) in the same cycle as a wren at ptr 3.
  - Response: data lands at 3, and the next write lands at 9.
- Reset mid-burst:
  - Stimulus: assert `bus_rst` between rden strobes.
  - Response: `user_r_data` = 0 and ptr = 0 immediately; memory contents are unchanged, verified by app read.
